cpu_mem_responder: RTL and testbench

- Memory-side responder for the 16-bit CPU's load/store bus; the CPU is the initiator.
- Accepts single-word read/write requests, inserts a configurable number of wait states, then returns a one-cycle ready pulse with read data or an error flag.
- Sits between CPU and on-chip data RAM; the CPU system testbench instantiates it beside the CPU.

---
 rtl/cpu_bus_pkg.sv | 15 +
 rtl/cpu_mem_array.sv | 33 +++
 rtl/cpu_mem_responder.sv | 156 +++++++++++++++
 tb/tb_cpu_mem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and widths for the CPU load/store bus responder.
package cpu_bus_pkg;

  localparam int unsigned CPU_DATA_W = 16;
  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_BE_W   = 2;
  localparam int unsigned CPU_WS_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_mem_array.sv
// Word RAM with synchronous byte-masked write and synchronous registered read; no reset.
module cpu_mem_array
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read register only updates on reads, so it holds across writes.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < int'(CPU_BE_W); b++) begin
        if (be[b]) mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (en && !we) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU load/store bus: latches one request, waits, then pulses ready.
module cpu_mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = CPU_ADDR_W,
  parameter int unsigned DATA_W      = CPU_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                state_q, state_d;
  logic [CPU_WS_W-1:0]   cnt_q, cnt_d;
  logic                  op_we_q, op_we_d;
  logic [1:0]            op_be_q, op_be_d;
  logic [IDX_W-1:0]      op_idx_q, op_idx_d;
  logic [DATA_W-1:0]     op_wdata_q, op_wdata_d;
  logic                  oor_q, oor_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;

  logic                  in_oor_c;
  logic                  go_resp_c;
  logic                  cur_we_c;
  logic [1:0]            cur_be_c;
  logic [IDX_W-1:0]      cur_idx_c;
  logic [DATA_W-1:0]     cur_wdata_c;
  logic                  cur_oor_c;
  logic                  mem_en_c;
  logic [DATA_W-1:0]     mem_rdata;

  assign in_oor_c = (33'(addr) >= 33'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_we_d     = op_we_q;
    op_be_d     = op_be_q;
    op_idx_d    = op_idx_q;
    op_wdata_d  = op_wdata_q;
    oor_d       = oor_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    rvalid_d    = rvalid_q;
    go_resp_c   = 1'b0;
    cur_we_c    = op_we_q;
    cur_be_c    = op_be_q;
    cur_idx_c   = op_idx_q;
    cur_wdata_c = op_wdata_q;
    cur_oor_c   = oor_q;

    unique case (state_q)
      ST_IDLE: begin
        // Live operands feed the RAM directly when there are no wait states.
        cur_we_c    = we;
        cur_be_c    = be;
        cur_idx_c   = addr[IDX_W-1:0];
        cur_wdata_c = wdata;
        cur_oor_c   = in_oor_c;
        if (req) begin
          op_we_d    = we;
          op_be_d    = be;
          op_idx_d   = addr[IDX_W-1:0];
          op_wdata_d = wdata;
          oor_d      = in_oor_c;
          if (WAIT_STATES == 0) begin
            state_d   = ST_RESP;
            go_resp_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CPU_WS_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CPU_WS_W'(1)) begin
          state_d   = ST_RESP;
          cnt_d     = '0;
          go_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CPU_WS_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (go_resp_c) begin
      ready_d = 1'b1;
      err_d   = cur_oor_c;
      if (!cur_we_c) rvalid_d = !cur_oor_c;
    end
  end

  // Gate with reset so nothing commits while reset is held.
  assign mem_en_c = go_resp_c && !cur_oor_c && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_we_q    <= 1'b0;
      op_be_q    <= '0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
      oor_q      <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_we_q    <= op_we_d;
      op_be_q    <= op_be_d;
      op_idx_q   <= op_idx_d;
      op_wdata_q <= op_wdata_d;
      oor_q      <= oor_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rvalid_q   <= rvalid_d;
    end
  end

  cpu_mem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en_c),
    .we    (cur_we_c),
    .be    (cur_be_c),
    .addr  (cur_idx_c),
    .wdata (cur_wdata_c),
    .rdata (mem_rdata)
  );

  // rdata reads as zero until an in-range read lands, and after an out-of-range read.
  assign ready = ready_q;
  assign err   = err_q;
  assign rdata = rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two instances (0 and 1 wait states) against a transaction-level model.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [1:0]  be_v    [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic        ready_v [2];
  logic        err_v   [2];
  logic [15:0] rdata_v [2];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit done     = 1'b0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_v[0]), .be(be_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0])
  );

  cpu_mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(256), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_v[1]), .be(be_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: an access accepted at edge N completes at edge N+WS,
  // and the responder can accept again at edge N+WS+2.
  int          ws_of   [2] = '{0, 1};
  int          cyc          = 0;
  int          free_at [2] = '{0, 0};
  int          resp_at [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  logic        m_we    [2];
  logic [1:0]  m_be    [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] mmem    [2][256];
  logic        exp_ready [2] = '{1'b0, 1'b0};
  logic        exp_err   [2] = '{1'b0, 1'b0};
  logic [15:0] exp_rdata [2] = '{16'h0, 16'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pend[i] = 1'b0;
        free_at[i] = 0;
        exp_ready[i] = 1'b0;
        exp_err[i] = 1'b0;
        exp_rdata[i] = 16'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_ready[i] = 1'b0;
        exp_err[i] = 1'b0;
        if (!pend[i] && cyc >= free_at[i] && req_v[i]) begin
          pend[i] = 1'b1;
          resp_at[i] = cyc + ws_of[i];
          free_at[i] = cyc + ws_of[i] + 2;
          m_we[i] = we_v[i];
          m_be[i] = be_v[i];
          m_addr[i] = addr_v[i];
          m_wdata[i] = wdata_v[i];
        end
        if (pend[i] && cyc == resp_at[i]) begin
          pend[i] = 1'b0;
          exp_ready[i] = 1'b1;
          if (int'(m_addr[i]) >= 256) begin
            exp_err[i] = 1'b1;
            if (!m_we[i]) exp_rdata[i] = 16'h0;
          end else if (m_we[i]) begin
            if (m_be[i][0]) mmem[i][m_addr[i][7:0]][7:0]  = m_wdata[i][7:0];
            if (m_be[i][1]) mmem[i][m_addr[i][7:0]][15:8] = m_wdata[i][15:8];
          end else begin
            exp_rdata[i] = mmem[i][m_addr[i][7:0]];
          end
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc_ready%0d", i), 32'(ready_v[i]), 32'(exp_ready[i]));
        chk($sformatf("cyc_err%0d", i),   32'(err_v[i]),   32'(exp_err[i]));
        chk($sformatf("cyc_rdata%0d", i), 32'(rdata_v[i]), 32'(exp_rdata[i]));
      end
    end
  end

  // Drives one access and waits (bounded) for its ready pulse; returns with the responder idle.
  task automatic txn(input int i, input logic w, input logic [1:0] b, input logic [15:0] a,
                     input logic [15:0] d, output logic [15:0] rd, output logic er, output int lat);
    bit got = 1'b0;
    req_v[i] = 1'b1; we_v[i] = w; be_v[i] = b; addr_v[i] = a; wdata_v[i] = d;
    lat = 0; rd = 16'hxxxx; er = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ready_v[i]) begin
        lat = k; rd = rdata_v[i]; er = err_v[i]; got = 1'b1;
        break;
      end
    end
    req_v[i] = 1'b0;
    if (!got) chk($sformatf("txn_timeout%0d", i), 32'(0), 32'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          edge_n, last_edge, pulses;
    bit          got;

    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b0; we_v[i] = 1'b0; be_v[i] = 2'b00; addr_v[i] = '0; wdata_v[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_v[1]), 32'(0));
    chk("rst_err",   32'(err_v[1]),   32'(0));
    chk("rst_rdata", 32'(rdata_v[1]), 32'(16'h0000));
    rst_n = 1'b1;

    // Basic write/read with one wait state.
    txn(1, 1'b1, 2'b11, 16'h0010, 16'hBEEF, rd, er, lat);
    chk("t1_wr_lat", 32'(lat), 32'(2));
    chk("t1_wr_err", 32'(er),  32'(0));
    chk("t1_wr_rdata_kept", 32'(rd), 32'(16'h0000));
    txn(1, 1'b0, 2'b00, 16'h0010, 16'h0000, rd, er, lat);
    chk("t1_rd_lat",  32'(lat), 32'(2));
    chk("t1_rd_data", 32'(rd),  32'(16'hBEEF));

    // Byte enables, including the empty mask.
    txn(1, 1'b1, 2'b11, 16'h0005, 16'h1234, rd, er, lat);
    txn(1, 1'b1, 2'b10, 16'h0005, 16'hAB00, rd, er, lat);
    txn(1, 1'b0, 2'b00, 16'h0005, 16'h0000, rd, er, lat);
    chk("t2_be10", 32'(rd), 32'(16'hAB34));
    txn(1, 1'b1, 2'b00, 16'h0005, 16'hFFFF, rd, er, lat);
    chk("t2_be00_lat", 32'(lat), 32'(2));
    txn(1, 1'b0, 2'b00, 16'h0005, 16'h0000, rd, er, lat);
    chk("t2_be00", 32'(rd), 32'(16'hAB34));

    // Range boundary: 0x00FF is the last word, 0x0100 and above error out.
    txn(1, 1'b1, 2'b11, 16'h0000, 16'h0A0A, rd, er, lat);
    txn(1, 1'b1, 2'b11, 16'h00FF, 16'hC3C3, rd, er, lat);
    txn(1, 1'b0, 2'b00, 16'h00FF, 16'h0000, rd, er, lat);
    chk("t3_last_data", 32'(rd), 32'(16'hC3C3));
    chk("t3_last_err",  32'(er), 32'(0));
    txn(1, 1'b0, 2'b00, 16'h0100, 16'h0000, rd, er, lat);
    chk("t3_oor_rd_err",  32'(er), 32'(1));
    chk("t3_oor_rd_data", 32'(rd), 32'(16'h0000));
    txn(1, 1'b1, 2'b11, 16'h0100, 16'hFFFF, rd, er, lat);
    chk("t3_oor_wr_err", 32'(er), 32'(1));
    txn(1, 1'b0, 2'b00, 16'h0000, 16'h0000, rd, er, lat);
    chk("t3_addr0_kept", 32'(rd), 32'(16'h0A0A));
    txn(1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, rd, er, lat);
    chk("t3_ffff_err", 32'(er), 32'(1));

    // Zero wait states, then back-to-back reads with req held high.
    for (int r = 0; r < 4; r++) begin
      txn(0, 1'b1, 2'b11, 16'(16'h0014 + r), 16'(16'hA000 + r), rd, er, lat);
      chk("t4_wr_lat", 32'(lat), 32'(1));
    end
    req_v[0] = 1'b1; we_v[0] = 1'b0; be_v[0] = 2'b00; addr_v[0] = 16'h0014;
    edge_n = 0; last_edge = 0;
    for (int r = 0; r < 4; r++) begin
      got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        edge_n++;
        if (ready_v[0]) begin got = 1'b1; break; end
      end
      if (!got) chk("t4_timeout", 32'(0), 32'(1));
      chk("t4_b2b_data", 32'(rdata_v[0]), 32'(16'hA000 + r));
      if (r > 0) chk("t4_gap", 32'(edge_n - last_edge), 32'(2));
      else chk("t4_first_lat", 32'(edge_n), 32'(1));
      last_edge = edge_n;
      addr_v[0] = 16'(16'h0015 + r);
    end
    req_v[0] = 1'b0;
    @(posedge clk); #1;

    // Reset during the wait state must abort the write.
    txn(1, 1'b1, 2'b11, 16'h0003, 16'h1111, rd, er, lat);
    req_v[1] = 1'b1; we_v[1] = 1'b1; be_v[1] = 2'b11; addr_v[1] = 16'h0003; wdata_v[1] = 16'h5555;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_v[1] = 1'b0;
    #1;
    chk("t5_ready_in_reset", 32'(ready_v[1]), 32'(0));
    @(posedge clk); #1;
    chk("t5_ready_held_low", 32'(ready_v[1]), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 2'b00, 16'h0003, 16'h0000, rd, er, lat);
    chk("t5_no_commit", 32'(rd), 32'(16'h1111));

    // Protocol violation: req dropped and addr changed right after acceptance.
    txn(1, 1'b1, 2'b11, 16'h0007, 16'h7777, rd, er, lat);
    txn(1, 1'b1, 2'b11, 16'h0008, 16'h8888, rd, er, lat);
    req_v[1] = 1'b1; we_v[1] = 1'b0; be_v[1] = 2'b00; addr_v[1] = 16'h0007;
    @(posedge clk); #1;
    req_v[1] = 1'b0; addr_v[1] = 16'h0008;
    got = 1'b0; lat = 1;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ready_v[1]) begin got = 1'b1; lat = k; break; end
    end
    if (!got) chk("t6_timeout", 32'(0), 32'(1));
    chk("t6_lat",  32'(lat), 32'(2));
    chk("t6_data", 32'(rdata_v[1]), 32'(16'h7777));
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ready_v[1]) pulses++;
    end
    chk("t6_single_pulse", 32'(pulses), 32'(0));
    chk("t6_rdata_held", 32'(rdata_v[1]), 32'(16'h7777));

    @(negedge clk);
    done = 1'b1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
